// File: rtl/fpu_add_subt_seq.sv
// Sequential IEEE-754 adder/subtractor.
// One operation at a time: IDLE latches operands on beg_FSM, then the
// datapath steps UNPACK -> ALIGN -> ADD -> NORM -> ROUND -> DONE, one state
// per clock. ready rises on the clock after DONE is entered (6 clocks after
// the edge that samples beg_FSM) and holds until rst_FSM releases the result.
// Handshake: beg_FSM is honoured only in IDLE; ready=1 means the result and
// flags are valid and stable; rst_FSM is honoured only in DONE and returns to
// IDLE (beg_FSM in that same cycle is ignored).
// Optional feature: define FPU_ADD_SUBT_RNE_EN for round-to-nearest-even;
// otherwise the guard/round/sticky bits are truncated.
module fpu_add_subt_seq #(
  parameter int W     = 32,
  parameter int W_Exp = 8,
  parameter int W_Sgf = 23
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         beg_FSM,
  input  logic         rst_FSM,
  input  logic [W-1:0] Data_X,
  input  logic [W-1:0] Data_Y,
  input  logic         add_subt,
  output logic         ready,
  output logic [W-1:0] final_result_ieee,
  output logic         overflow_flag,
  output logic         underflow_flag
);

  localparam int BIAS = 2**(W_Exp-1) - 1;
  localparam int M    = W_Sgf + 1;          // significand with hidden bit
  localparam int EXT  = M + 3;              // significand plus guard/round/sticky
  localparam int SUM  = EXT + 1;            // one carry bit on top
  localparam int EW   = W_Exp + 2;          // exponent with sign and headroom
  localparam int LZW  = $clog2(EXT + 1);

  localparam logic [EW-1:0]    EXP_MAX   = EW'(2 * BIAS + 1);
  localparam logic [W_Exp-1:0] MAX_SHIFT = W_Exp'(EXT - 2);

  typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, DONE} state_t;

  state_t state;

  // latched request
  logic [W-1:0] x_q, y_q;
  logic         op_q;

  // unpacked, ordered operands (A has the larger magnitude)
  logic [W_Exp-1:0] a_exp_q, b_exp_q;
  logic [M-1:0]     a_man_q, b_man_q;
  logic             res_sign_q, eff_sub_q, inf_q, inf_sign_q;

  // aligned operands, raw sum, normalized result
  logic [EXT-1:0]   a_ext_q, b_ext_q;
  logic [SUM-1:0]   sum_q;
  logic [EXT-1:0]   norm_q;
  logic [EW-1:0]    norm_exp_q;
  logic             zero_q;

  // ---------------- UNPACK combinational view ----------------
  logic             x_sign, y_sign_eff;
  logic [W_Exp-1:0] x_exp, y_exp;
  logic [W-2:0]     x_mag, y_mag;
  logic [M-1:0]     x_man, y_man;
  logic             x_inf, y_inf, swap;

  // Decode both operands, flushing denormals to zero, and pick the larger.
  always_comb begin
    x_sign     = x_q[W-1];
    y_sign_eff = y_q[W-1] ^ op_q;
    x_exp      = x_q[W-2:W_Sgf];
    y_exp      = y_q[W-2:W_Sgf];
    x_mag      = (x_exp == '0) ? '0 : x_q[W-2:0];
    y_mag      = (y_exp == '0) ? '0 : y_q[W-2:0];
    x_man      = (x_exp == '0) ? '0 : {1'b1, x_q[W_Sgf-1:0]};
    y_man      = (y_exp == '0) ? '0 : {1'b1, y_q[W_Sgf-1:0]};
    x_inf      = &x_exp;
    y_inf      = &y_exp;
    swap       = (y_mag > x_mag);
  end

  // ---------------- ALIGN combinational view ----------------
  logic [W_Exp-1:0] exp_diff;
  logic [EXT-1:0]   b_full, b_shifted, b_aligned;
  logic             b_lost;

  // Right-shift B by the exponent difference, folding lost bits into sticky.
  always_comb begin
    exp_diff  = a_exp_q - b_exp_q;
    b_full    = {b_man_q, 3'b000};
    b_shifted = b_full >> exp_diff;
    b_lost    = |(b_full & ~({EXT{1'b1}} << exp_diff));
    if (exp_diff > MAX_SHIFT) begin
      b_aligned = {{(EXT-1){1'b0}}, |b_man_q};
    end else begin
      b_aligned = b_shifted | {{(EXT-1){1'b0}}, b_lost};
    end
  end

  // ---------------- NORM combinational view ----------------
  logic [LZW-1:0] lz_cnt;
  logic           lz_hit;
  logic [EXT-1:0] norm_val;
  logic [EW-1:0]  norm_exp;

  // Leading-zero count and single-cycle normalization of the raw sum.
  always_comb begin
    lz_cnt = '0;
    lz_hit = 1'b0;
    for (int i = EXT - 1; i >= 0; i--) begin
      if (!lz_hit) begin
        if (sum_q[i]) lz_hit = 1'b1;
        else          lz_cnt = lz_cnt + 1'b1;
      end
    end
    if (sum_q[SUM-1]) begin
      norm_val = sum_q[SUM-1:1] | {{(EXT-1){1'b0}}, sum_q[0]};
      norm_exp = {2'b00, a_exp_q} + EW'(1);
    end else begin
      norm_val = sum_q[EXT-1:0] << lz_cnt;
      norm_exp = {2'b00, a_exp_q} - {{(EW-LZW){1'b0}}, lz_cnt};
    end
  end

  // ---------------- ROUND combinational view ----------------
  logic           round_up;
  logic [M:0]     man_r;
  logic [W_Sgf-1:0] frac_r;
  logic [EW-1:0]  exp_r;
  logic [W-1:0]   res_val;
  logic           ov_val, uf_val;

`ifdef FPU_ADD_SUBT_RNE_EN
  // Round to nearest, ties to even, from guard/round/sticky.
  always_comb begin
    round_up = norm_q[2] & (norm_q[1] | norm_q[0] | norm_q[3]);
  end
`else
  logic unused_grs;
  assign unused_grs = ^norm_q[2:0];
  // Truncation: guard/round/sticky are dropped.
  always_comb begin
    round_up = 1'b0;
  end
`endif

  // Apply rounding, renormalize on carry-out, then resolve special cases.
  always_comb begin
    man_r  = {1'b0, norm_q[EXT-1:3]} + {{M{1'b0}}, round_up};
    frac_r = man_r[M] ? man_r[M-1:1] : man_r[M-2:0];
    exp_r  = man_r[M] ? norm_exp_q + EW'(1) : norm_exp_q;
    ov_val  = 1'b0;
    uf_val  = 1'b0;
    res_val = {res_sign_q, exp_r[W_Exp-1:0], frac_r};
    if (inf_q) begin
      res_val = {inf_sign_q, {W_Exp{1'b1}}, {W_Sgf{1'b0}}};
      ov_val  = 1'b1;
    end else if (zero_q) begin
      res_val = '0;
    end else if (exp_r[EW-1] || (exp_r == '0)) begin
      res_val = {res_sign_q, {(W-1){1'b0}}};
      uf_val  = 1'b1;
    end else if (exp_r >= EXP_MAX) begin
      res_val = {res_sign_q, {W_Exp{1'b1}}, {W_Sgf{1'b0}}};
      ov_val  = 1'b1;
    end
  end

  // Control FSM plus per-stage datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      ready             <= 1'b0;
      final_result_ieee <= '0;
      overflow_flag     <= 1'b0;
      underflow_flag    <= 1'b0;
      x_q               <= '0;
      y_q               <= '0;
      op_q              <= 1'b0;
      a_exp_q           <= '0;
      b_exp_q           <= '0;
      a_man_q           <= '0;
      b_man_q           <= '0;
      res_sign_q        <= 1'b0;
      eff_sub_q         <= 1'b0;
      inf_q             <= 1'b0;
      inf_sign_q        <= 1'b0;
      a_ext_q           <= '0;
      b_ext_q           <= '0;
      sum_q             <= '0;
      norm_q            <= '0;
      norm_exp_q        <= '0;
      zero_q            <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ready <= 1'b0;
          if (beg_FSM) begin
            x_q   <= Data_X;
            y_q   <= Data_Y;
            op_q  <= add_subt;
            state <= UNPACK;
          end
        end
        UNPACK: begin
          a_exp_q    <= swap ? y_exp : x_exp;
          b_exp_q    <= swap ? x_exp : y_exp;
          a_man_q    <= swap ? y_man : x_man;
          b_man_q    <= swap ? x_man : y_man;
          res_sign_q <= swap ? y_sign_eff : x_sign;
          eff_sub_q  <= x_sign ^ y_sign_eff;
          inf_q      <= x_inf | y_inf;
          inf_sign_q <= x_inf ? x_sign : y_sign_eff;
          state      <= ALIGN;
        end
        ALIGN: begin
          a_ext_q <= {a_man_q, 3'b000};
          b_ext_q <= b_aligned;
          state   <= ADD;
        end
        ADD: begin
          sum_q <= eff_sub_q ? ({1'b0, a_ext_q} - {1'b0, b_ext_q})
                             : ({1'b0, a_ext_q} + {1'b0, b_ext_q});
          state <= NORM;
        end
        NORM: begin
          norm_q     <= norm_val;
          norm_exp_q <= norm_exp;
          zero_q     <= (sum_q == '0);
          state      <= ROUND;
        end
        ROUND: begin
          final_result_ieee <= res_val;
          overflow_flag     <= ov_val;
          underflow_flag    <= uf_val;
          state             <= DONE;
        end
        DONE: begin
          if (rst_FSM) begin
            ready <= 1'b0;
            state <= IDLE;
          end else begin
            ready <= 1'b1;
          end
        end
        default: begin
          ready <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_add_subt_seq.sv
// Directed bench for fpu_add_subt_seq: hand-computed vectors, ready latency,
// hold/release handshake, mid-operation reset. Build with
// +define+FPU_ADD_SUBT_RNE_EN to check the round-to-nearest-even variant.
module tb_fpu_add_subt_seq;

  logic        clk;
  logic        rst;
  logic        beg_FSM;
  logic        rst_FSM;
  logic [31:0] Data_X;
  logic [31:0] Data_Y;
  logic        add_subt;
  logic        ready;
  logic [31:0] final_result_ieee;
  logic        overflow_flag;
  logic        underflow_flag;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  fpu_add_subt_seq #(.W(32), .W_Exp(8), .W_Sgf(23)) dut (
    .clk               (clk),
    .rst               (rst),
    .beg_FSM           (beg_FSM),
    .rst_FSM           (rst_FSM),
    .Data_X            (Data_X),
    .Data_Y            (Data_Y),
    .add_subt          (add_subt),
    .ready             (ready),
    .final_result_ieee (final_result_ieee),
    .overflow_flag     (overflow_flag),
    .underflow_flag    (underflow_flag)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Driver: one full transaction with latency, result and release checks.
  task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                        input logic op, input logic [31:0] exp_res,
                        input logic exp_ov, input logic exp_uf);
    logic [31:0] expv;
    exp_q.push_back(exp_res);
    @(negedge clk);
    Data_X = x; Data_Y = y; add_subt = op; beg_FSM = 1'b1;
    @(posedge clk);
    #1;
    beg_FSM  = 1'b0;
    Data_X   = $urandom;
    Data_Y   = $urandom;
    add_subt = 1'($urandom_range(0, 1));
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      check({tag, "_ready_c", $sformatf("%0d", k)}, {31'd0, ready}, (k == 6) ? 32'd1 : 32'd0);
    end
    expv = exp_q.pop_front();
    check({tag, "_res"}, final_result_ieee, expv);
    check({tag, "_ovf"}, {31'd0, overflow_flag}, {31'd0, exp_ov});
    check({tag, "_unf"}, {31'd0, underflow_flag}, {31'd0, exp_uf});
    @(negedge clk);
    rst_FSM = 1'b1;
    @(posedge clk);
    #1;
    rst_FSM = 1'b0;
    check({tag, "_rel_ready"}, {31'd0, ready}, 32'd0);
    check({tag, "_rel_hold"}, final_result_ieee, expv);
  endtask

  // Wait n cycles and require ready to stay low throughout.
  task automatic expect_idle(input string tag, input int n);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (ready) seen = 1'b1;
    end
    check(tag, {31'd0, seen}, 32'd0);
  endtask

  logic [31:0] rne_a, rne_b;

  initial begin
`ifdef FPU_ADD_SUBT_RNE_EN
    rne_a = 32'h3F800001;
    rne_b = 32'h3F800002;
`else
    rne_a = 32'h3F800000;
    rne_b = 32'h3F800001;
`endif
    rst = 1'b1; beg_FSM = 1'b0; rst_FSM = 1'b0;
    Data_X = '0; Data_Y = '0; add_subt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_res", final_result_ieee, 32'd0);
    check("rst_ovf", {31'd0, overflow_flag}, 32'd0);
    check("rst_unf", {31'd0, underflow_flag}, 32'd0);
    rst = 1'b0;

    run_op("one_plus_one",   32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0);
    run_op("three_minus_one",32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 1'b0, 1'b0);
    run_op("cancel",         32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0, 1'b0);
    run_op("round_a",        32'h3F800000, 32'h33C00000, 1'b0, rne_a,        1'b0, 1'b0);
    run_op("round_b",        32'h3F800001, 32'h33800000, 1'b0, rne_b,        1'b0, 1'b0);
    run_op("swap_neg",       32'h3F800000, 32'h40400000, 1'b1, 32'hC0000000, 1'b0, 1'b0);
    run_op("neg_add",        32'hBF800000, 32'hBF800000, 1'b0, 32'hC0000000, 1'b0, 1'b0);
    run_op("carry_2p5",      32'h3F800000, 32'h3FC00000, 1'b0, 32'h40200000, 1'b0, 1'b0);
    run_op("lzc_0p25",       32'h3F800000, 32'h3F400000, 1'b1, 32'h3E800000, 1'b0, 1'b0);
    run_op("denorm_flush",   32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 1'b0, 1'b0);
    run_op("underflow",      32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 1'b0, 1'b1);
    run_op("inf_x",          32'h7F800000, 32'h3F800000, 1'b1, 32'h7F800000, 1'b1, 1'b0);
    run_op("inf_y_sub",      32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 1'b1, 1'b0);
    run_op("overflow",       32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0);

    // Reset in ALIGN clears everything; previous result was overflow.
    @(negedge clk);
    Data_X = 32'h3F800000; Data_Y = 32'h3F800000; add_subt = 1'b0; beg_FSM = 1'b1;
    @(posedge clk);
    #1;
    beg_FSM = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_ready", {31'd0, ready}, 32'd0);
    check("midrst_res", final_result_ieee, 32'd0);
    check("midrst_ovf", {31'd0, overflow_flag}, 32'd0);
    check("midrst_unf", {31'd0, underflow_flag}, 32'd0);
    expect_idle("midrst_no_resume", 8);

    // beg_FSM held through busy and DONE; operands scrambled after capture.
    exp_q.push_back(32'h40000000);
    @(negedge clk);
    Data_X = 32'h3F800000; Data_Y = 32'h3F800000; add_subt = 1'b0; beg_FSM = 1'b1;
    @(posedge clk);
    #1;
    Data_X = 32'h40400000;
    Data_Y = 32'hC1200000;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("hold_ready_c%0d", k), {31'd0, ready}, (k == 6) ? 32'd1 : 32'd0);
    end
    begin
      logic [31:0] expv;
      expv = exp_q.pop_front();
      for (int k = 0; k < 5; k++) begin
        @(posedge clk);
        #1;
        check($sformatf("hold_ready_d%0d", k), {31'd0, ready}, 32'd1);
        check($sformatf("hold_res_d%0d", k), final_result_ieee, expv);
      end
    end
    // beg_FSM and rst_FSM together in DONE: return to IDLE, no restart.
    @(negedge clk);
    rst_FSM = 1'b1;
    @(posedge clk);
    #1;
    beg_FSM = 1'b0;
    rst_FSM = 1'b0;
    check("both_ready", {31'd0, ready}, 32'd0);
    check("both_hold", final_result_ieee, 32'h40000000);
    expect_idle("both_no_start", 8);

    // Release with beg_FSM low outside DONE is harmless.
    @(negedge clk);
    rst_FSM = 1'b1;
    @(posedge clk);
    #1;
    rst_FSM = 1'b0;
    expect_idle("stray_rst_fsm", 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
